// File: rtl/irq_vector_ctrl.sv
// -----------------------------------------------------------------------------
// irq_vector_ctrl
//
// Registered interrupt-vector controller sitting behind an 8-to-3 active-low
// priority encoder. The encoder outputs are synchronised, a request is
// qualified once it has been stable for STABLE_CYCLES samples, and the
// true-sense vector is then offered to the CPU through a valid/ack/eoi
// handshake. While a vector is pending or in service the encoder is masked
// through EI_bar.
//
// Optional feature macro: IRQ_TIMEOUT_EN
//   defined   : a service timeout of TIMEOUT_CYCLES returns the block to IDLE
//               and pulses irq_timeout for one cycle.
//   undefined : SERV waits indefinitely for eoi; irq_timeout is constant 0.
//
// Parameters
//   STABLE_CYCLES  : identical synchronised samples needed to accept (1..15)
//   TIMEOUT_CYCLES : service timeout in cycles (1..65535, IRQ_TIMEOUT_EN only)
//
// Ports
//   clk         in   rising-edge clock
//   rst_bar     in   asynchronous active-low reset
//   GS_bar      in   encoder group select (0 = request active)
//   Y_bar[2:0]  in   encoder active-low code
//   EI_bar      out  encoder enable, registered (1 = masked)
//   irq_valid   out  vector pending, registered
//   irq_vec     out  true-sense channel number, registered
//   irq_ack     in   CPU accepts the pending vector
//   irq_eoi     in   CPU end-of-interrupt
//   irq_busy    out  vector in service, registered
//   irq_timeout out  one-cycle service-timeout pulse, registered
// -----------------------------------------------------------------------------
module irq_vector_ctrl #(
   parameter int unsigned STABLE_CYCLES  = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_bar,
   input  logic       GS_bar,
   input  logic [2:0] Y_bar,
   output logic       EI_bar,
   output logic       irq_valid,
   output logic [2:0] irq_vec,
   input  logic       irq_ack,
   input  logic       irq_eoi,
   output logic       irq_busy,
   output logic       irq_timeout
);

   localparam logic [3:0] STABLE_L = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_QUAL = 2'd1,
      ST_PEND = 2'd2,
      ST_SERV = 2'd3
   } state_t;

   // Synchroniser stages
   logic       gs_meta_r;
   logic       gs_sync_r;
   logic [2:0] y_meta_r;
   logic [2:0] y_sync_r;

   // FSM state and qualification bookkeeping
   state_t     state_r;
   state_t     state_s;
   logic [2:0] cand_r;
   logic [2:0] cand_s;
   logic [3:0] cnt_r;
   logic [3:0] cnt_s;
   logic [3:0] cnt_inc_s;

   // Registered outputs and their next values
   logic       ei_r;
   logic       valid_r;
   logic       busy_r;
   logic       tmo_r;
   logic       tmo_s;
   logic [2:0] vec_r;
   logic [2:0] vec_s;

`ifdef IRQ_TIMEOUT_EN
   logic [15:0] to_cnt_r;
   logic [15:0] to_cnt_s;
   logic        to_limit_s;
`endif

   assign cnt_inc_s = cnt_r + 4'd1;

`ifdef IRQ_TIMEOUT_EN
   // The limit is hit on the edge where the incremented count would equal it
   assign to_limit_s = (({1'b0, to_cnt_r} + 17'd1) == 17'(TIMEOUT_CYCLES));
`endif

   // Two-flop synchronisers, preset to "no request"
   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) begin
         gs_meta_r <= 1'b1;
         gs_sync_r <= 1'b1;
         y_meta_r  <= 3'b111;
         y_sync_r  <= 3'b111;
      end else begin
         gs_meta_r <= GS_bar;
         gs_sync_r <= gs_meta_r;
         y_meta_r  <= Y_bar;
         y_sync_r  <= y_meta_r;
      end
   end

   // Next-state, qualification and vector-latch logic
   always_comb begin
      state_s = state_r;
      cand_s  = cand_r;
      cnt_s   = cnt_r;
      vec_s   = vec_r;
      tmo_s   = 1'b0;
`ifdef IRQ_TIMEOUT_EN
      to_cnt_s = to_cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (!gs_sync_r) begin
               cand_s = y_sync_r;
               cnt_s  = 4'd1;
               if (STABLE_L == 4'd1) begin
                  state_s = ST_PEND;
                  vec_s   = ~y_sync_r;
               end else begin
                  state_s = ST_QUAL;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_QUAL: begin
            if (gs_sync_r) begin
               state_s = ST_IDLE;
            end else if (y_sync_r == cand_r) begin
               cnt_s = cnt_inc_s;
               // Exit on the equality compare so the 4-bit count never wraps
               if (cnt_inc_s == STABLE_L) begin
                  state_s = ST_PEND;
                  vec_s   = ~cand_r;
               end else begin
                  state_s = ST_QUAL;
               end
            end else begin
               // Code changed mid-qualification: restart on the new code
               cand_s = y_sync_r;
               cnt_s  = 4'd1;
            end
         end
         ST_PEND: begin
            // ack wins over a simultaneous eoi; eoi is ignored here
            if (irq_ack) begin
               state_s = ST_SERV;
`ifdef IRQ_TIMEOUT_EN
               to_cnt_s = 16'd0;
`endif
            end else begin
               state_s = ST_PEND;
            end
         end
         ST_SERV: begin
            if (irq_eoi) begin
               state_s = ST_IDLE;
            end else begin
`ifdef IRQ_TIMEOUT_EN
               if (to_limit_s) begin
                  state_s = ST_IDLE;
                  tmo_s   = 1'b1;
               end else begin
                  to_cnt_s = to_cnt_r + 16'd1;
               end
`else
               state_s = ST_SERV;
`endif
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, qualification registers and registered outputs
   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) begin
         state_r <= ST_IDLE;
         cand_r  <= 3'b111;
         cnt_r   <= 4'd0;
         vec_r   <= 3'b000;
         ei_r    <= 1'b1;
         valid_r <= 1'b0;
         busy_r  <= 1'b0;
         tmo_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         cand_r  <= cand_s;
         cnt_r   <= cnt_s;
         vec_r   <= vec_s;
         ei_r    <= (state_s == ST_PEND) || (state_s == ST_SERV);
         valid_r <= (state_s == ST_PEND);
         busy_r  <= (state_s == ST_SERV);
         tmo_r   <= tmo_s;
      end
   end

`ifdef IRQ_TIMEOUT_EN
   // Service-time counter
   always_ff @(posedge clk or negedge rst_bar) begin
      if (!rst_bar) begin
         to_cnt_r <= 16'd0;
      end else begin
         to_cnt_r <= to_cnt_s;
      end
   end
`endif

   assign EI_bar      = ei_r;
   assign irq_valid   = valid_r;
   assign irq_vec     = vec_r;
   assign irq_busy    = busy_r;
   assign irq_timeout = tmo_r;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for irq_vector_ctrl. Instance 0 qualifies after two
// samples, instance 1 after three. Expected vectors are queued when a request
// is driven and popped when irq_valid is seen.
// -----------------------------------------------------------------------------
module tb_irq_vector_ctrl;

   logic       clk;
   logic       rst_bar;
   logic       gs_bar [2];
   logic [2:0] y_bar  [2];
   logic       ack    [2];
   logic       eoi    [2];
   logic       ei_bar [2];
   logic       valid  [2];
   logic [2:0] vec    [2];
   logic       busy   [2];
   logic       tmo    [2];

   int total;
   int bad;
   int exp_q[$];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      irq_vector_ctrl #(
         .STABLE_CYCLES  ((g == 0) ? 2 : 3),
         .TIMEOUT_CYCLES (10)
      ) u_dut (
         .clk         (clk),
         .rst_bar     (rst_bar),
         .GS_bar      (gs_bar[g]),
         .Y_bar       (y_bar[g]),
         .EI_bar      (ei_bar[g]),
         .irq_valid   (valid[g]),
         .irq_vec     (vec[g]),
         .irq_ack     (ack[g]),
         .irq_eoi     (eoi[g]),
         .irq_busy    (busy[g]),
         .irq_timeout (tmo[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait (bounded) for irq_valid, then compare against the scoreboard
   task automatic wait_valid(input int idx, input string tag);
      int exp_v;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (valid[idx]) break;
      end
      chk({tag, "_valid"}, 32'(valid[idx]), 32'd1);
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         chk({tag, "_vec"}, 32'(vec[idx]), 32'(exp_v));
      end
   endtask

   task automatic service(input int idx);
      ack[idx] = 1'b1;
      @(negedge clk);
      ack[idx] = 1'b0;
      eoi[idx] = 1'b1;
      @(negedge clk);
      eoi[idx] = 1'b0;
   endtask

   initial begin
      logic quiet;
      total   = 0;
      bad     = 0;
      rst_bar = 1'b0;
      for (int i = 0; i < 2; i++) begin
         gs_bar[i] = 1'b1;
         y_bar[i]  = 3'b111;
         ack[i]    = 1'b0;
         eoi[i]    = 1'b0;
      end
      cyc(2);
      for (int i = 0; i < 2; i++) begin
         chk("rst_ei", 32'(ei_bar[i]), 32'd1);
         chk("rst_valid", 32'(valid[i]), 32'd0);
         chk("rst_busy", 32'(busy[i]), 32'd0);
         chk("rst_vec", 32'(vec[i]), 32'd0);
         chk("rst_tmo", 32'(tmo[i]), 32'd0);
      end

      // Reset release with no request
      rst_bar = 1'b1;
      @(negedge clk);
      chk("rel_ei0", 32'(ei_bar[0]), 32'd0);
      chk("rel_ei1", 32'(ei_bar[1]), 32'd0);
      quiet = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (valid[0] || valid[1]) quiet = 1'b0;
      end
      chk("idle_quiet", 32'(quiet), 32'd1);

      // Latency: request before edge N, valid after edge N+3
      gs_bar[0] = 1'b0;
      y_bar[0]  = 3'b000;
      exp_q.push_back(7);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("lat_early", 32'(valid[0]), 32'd0);
      end
      wait_valid(0, "lat");
      chk("lat_ei", 32'(ei_bar[0]), 32'd1);
      gs_bar[0] = 1'b1;

      // eoi while pending is ignored
      eoi[0] = 1'b1;
      @(negedge clk);
      eoi[0] = 1'b0;
      chk("eoi_pend_valid", 32'(valid[0]), 32'd1);
      chk("eoi_pend_busy", 32'(busy[0]), 32'd0);

      ack[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;
      chk("ack_valid", 32'(valid[0]), 32'd0);
      chk("ack_busy", 32'(busy[0]), 32'd1);
      chk("ack_ei", 32'(ei_bar[0]), 32'd1);
      eoi[0] = 1'b1;
      @(negedge clk);
      eoi[0] = 1'b0;
      chk("eoi_busy", 32'(busy[0]), 32'd0);
      chk("eoi_ei", 32'(ei_bar[0]), 32'd0);
      chk("eoi_vec_hold", 32'(vec[0]), 32'd7);

      // ack while idle is ignored
      ack[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;
      chk("ack_idle_busy", 32'(busy[0]), 32'd0);
      chk("ack_idle_valid", 32'(valid[0]), 32'd0);

      // Vector 4; ack and eoi together leave the block in service
      gs_bar[0] = 1'b0;
      y_bar[0]  = 3'b011;
      exp_q.push_back(4);
      wait_valid(0, "v4");
      gs_bar[0] = 1'b1;
      ack[0] = 1'b1;
      eoi[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;
      eoi[0] = 1'b0;
      chk("ackeoi_valid", 32'(valid[0]), 32'd0);
      chk("ackeoi_busy", 32'(busy[0]), 32'd1);
      cyc(3);
      chk("serv_hold_busy", 32'(busy[0]), 32'd1);
      chk("serv_hold_vec", 32'(vec[0]), 32'd4);
      eoi[0] = 1'b1;
      @(negedge clk);
      eoi[0] = 1'b0;
      chk("v4_eoi_busy", 32'(busy[0]), 32'd0);
      chk("v4_eoi_ei", 32'(ei_bar[0]), 32'd0);

      // Second request qualifies normally
      gs_bar[0] = 1'b0;
      y_bar[0]  = 3'b101;
      exp_q.push_back(2);
      wait_valid(0, "v2");
      gs_bar[0] = 1'b1;
      service(0);

      // Reset asserted in service
      gs_bar[0] = 1'b0;
      y_bar[0]  = 3'b010;
      exp_q.push_back(5);
      wait_valid(0, "v5");
      gs_bar[0] = 1'b1;
      ack[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;
      chk("v5_busy", 32'(busy[0]), 32'd1);
      #2 rst_bar = 1'b0;
      #1;
      chk("arst_ei", 32'(ei_bar[0]), 32'd1);
      chk("arst_busy", 32'(busy[0]), 32'd0);
      chk("arst_vec", 32'(vec[0]), 32'd0);
      chk("arst_valid", 32'(valid[0]), 32'd0);
      @(negedge clk);
      rst_bar = 1'b1;
      @(negedge clk);
      chk("rerel_ei", 32'(ei_bar[0]), 32'd0);

      // Glitch rejection, three samples: 010 twice then 101 held -> vector 2
      gs_bar[1] = 1'b0;
      y_bar[1]  = 3'b010;
      cyc(2);
      y_bar[1]  = 3'b101;
      exp_q.push_back(2);
      wait_valid(1, "glitch");
      gs_bar[1] = 1'b1;
      service(1);

      // One-cycle GS_bar pulse must not qualify
      gs_bar[1] = 1'b0;
      y_bar[1]  = 3'b000;
      @(negedge clk);
      gs_bar[1] = 1'b1;
      quiet = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (valid[1]) quiet = 1'b0;
      end
      chk("pulse_reject", 32'(quiet), 32'd1);

      // Service timeout behaviour
      gs_bar[1] = 1'b0;
      y_bar[1]  = 3'b110;
      exp_q.push_back(1);
      wait_valid(1, "v1");
      gs_bar[1] = 1'b1;
      ack[1] = 1'b1;
      @(negedge clk);
      ack[1] = 1'b0;
      chk("to_entry_busy", 32'(busy[1]), 32'd1);
`ifdef IRQ_TIMEOUT_EN
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k < 10) begin
            chk("to_wait_tmo", 32'(tmo[1]), 32'd0);
            chk("to_wait_busy", 32'(busy[1]), 32'd1);
         end else begin
            chk("to_pulse", 32'(tmo[1]), 32'd1);
            chk("to_busy", 32'(busy[1]), 32'd0);
            chk("to_ei", 32'(ei_bar[1]), 32'd0);
         end
      end
      @(negedge clk);
      chk("to_pulse_end", 32'(tmo[1]), 32'd0);
`else
      quiet = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (tmo[1] || !busy[1]) quiet = 1'b0;
      end
      chk("no_timeout", 32'(quiet), 32'd1);
      eoi[1] = 1'b1;
      @(negedge clk);
      eoi[1] = 1'b0;
      chk("late_eoi_busy", 32'(busy[1]), 32'd0);
`endif
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
